window_spill_fill: RTL and testbench
====================================

WINDOW_SPILL_FILL -- requirements
Module: window_spill_fill

Interface
REQ-001 The block SHALL have parameters NUM_WIN, default 8, number of 4-register windows in the 32-entry register file.
REQ-002 The block SHALL have parameter SPILL_BASE, default 16'hF000, the lowest memory address of the spill stack.
REQ-003 The block SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-004 reset_L  in  1  asynchronous, active-low reset.
REQ-005 win_req  in  2  window request from control: 10 = save (+4), 01 = restore (-4), 00/11 = none; held until win_go.
REQ-006 index  in  5  current window index from the register file.
REQ-007 win_go  out  2  one-cycle pulse, same encoding as win_req, driven to the register file's winAddSub.
REQ-008 stall  out  1  high while a spill or fill is in progress.
REQ-009 rf_sel  out  5  physical register index for spill read or fill write.
REQ-010 rf_rdata  in  16  combinational read data for rf_sel.
REQ-011 rf_wdata  out  16  fill write data.
REQ-012 rf_load_L  out  1  active-low register-file write strobe.
REQ-013 mem_req, mem_we  out  1 each  memory request and write-enable.
REQ-014 mem_addr, mem_wdata  out  16 each  memory address and write data.
REQ-015 mem_rdata  in  16  memory read data, valid with mem_ack.
REQ-016 mem_ack  in  1  memory completion, may be asserted in the same cycle as mem_req.
REQ-017 depth  out  3  number of resident windows (1..NUM_WIN-1).
REQ-018 underflow  out  1  sticky error flag.

Function
REQ-019 The FSM SHALL have states IDLE, SPILL, FILL and GO.
REQ-020 In IDLE with save requested and depth < NUM_WIN-1: the FSM SHALL go to GO, and win_go = 10 SHALL pulse on the next cycle; depth increments.
REQ-021 In IDLE with save requested and depth == NUM_WIN-1: the FSM SHALL enter SPILL.
REQ-022 In SPILL, the FSM SHALL write physical registers (index - 4*(depth-1) + k) mod 32, k = 0..3, to mem_addr sp+k.
REQ-023 After the fourth ack in SPILL: sp += 4, depth -= 1, then GO as in REQ-020.
REQ-024 In IDLE with restore requested and depth > 1: the FSM SHALL go to GO with win_go = 01; depth decrements.
REQ-025 In IDLE with restore requested, depth == 1 and sp != SPILL_BASE: the FSM SHALL enter FILL.
REQ-026 In FILL, the FSM SHALL read mem_addr sp-4+k, k = 0..3, and write the result to physical register (index - 4 + k) mod 32 via a one-cycle rf_load_L low in the ack cycle.
REQ-027 After FILL: sp -= 4, then GO with win_go = 01; depth stays 1.
REQ-028 Restore with depth == 1 and sp == SPILL_BASE SHALL set underflow, emit no win_go, and return to IDLE.
REQ-029 Memory handshake: mem_req, mem_we, mem_addr and mem_wdata SHALL be held stable until mem_ack; at most one transaction is outstanding; the next transaction starts the cycle after an ack.
REQ-030 With zero-wait ack, a spill or fill SHALL take 4 cycles plus 1 GO cycle.
REQ-031 stall SHALL be high in SPILL and FILL, and low in IDLE and GO.
REQ-032 win_req = 11 SHALL be ignored.
REQ-033 win_req SHALL be sampled only in IDLE.
REQ-034 sp arithmetic SHALL be 16-bit modulo, with no overflow detection.
REQ-035 Physical index arithmetic SHALL be 5-bit modulo 32.

Reset
REQ-036 While reset_L is low, asynchronously: state = IDLE, depth = 1, sp = SPILL_BASE, underflow = 0, win_go = 00, stall = 0, mem_req = 0, mem_we = 0, rf_load_L = 1, mem_addr = 0, mem_wdata = 0, rf_sel = 0, rf_wdata = 0.
REQ-037 Reset mid-spill or mid-fill SHALL abort the operation with no sp or depth update; partially written memory or registers are not restored.

Structure
REQ-038 Package window_pkg SHALL hold NUM_WIN, WIN_REGS (4), SPILL_BASE and the FSM state enum.
REQ-039 sp SHALL be held in an instance of the existing register module (WIDTH 16).
REQ-040 The k counter SHALL be a 2-bit internal counter.

Verification
REQ-041 Reset, then save with win_req = 10 held -> win_go = 10 one cycle later, depth 1 -> 2, no mem_req.
REQ-042 Six saves to depth 7 with index = 24, then a seventh save -> 4 writes to F000..F003 of physical registers 0..3, then win_go = 10, sp = F004, depth = 7.
REQ-043 From sp = F004, depth = 1, index = 4, restore -> reads F000..F003 written into physical registers 0..3, sp = F000, win_go = 01.
REQ-044 Restore at depth = 1 and sp = F000 -> underflow = 1, no win_go, no mem_req.
REQ-045 Spill with mem_ack delayed 3 cycles per access -> mem_addr and mem_wdata stable while waiting, stall high throughout, 16 cycles of stall total.
REQ-046 reset_L asserted after the second ack of a spill -> all outputs at reset values immediately, sp = F000, depth = 1.

Source files
------------

// File: rtl/window_pkg.sv
// Shared constants and FSM state type for the register-window spill/fill controller.
package window_pkg;

    localparam int          NUM_WIN    = 8;         // 4-register windows in the 32-entry file
    localparam int          WIN_REGS   = 4;         // registers per window
    localparam logic [15:0] SPILL_BASE = 16'hF000;  // lowest address of the spill stack

    // Window request / window-go encoding shared with control and the register file
    localparam logic [1:0] WIN_NONE    = 2'b00;
    localparam logic [1:0] WIN_RESTORE = 2'b01;
    localparam logic [1:0] WIN_SAVE    = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPILL = 2'd1,
        FILL  = 2'd2,
        GO    = 2'd3
    } state_t;

endpackage

// File: rtl/window_spill_fill_if.sv
// Bundles the control, register-file and memory signals of the spill/fill controller.
interface window_spill_fill_if;

    logic [1:0]  win_req;
    logic [4:0]  index;
    logic [1:0]  win_go;
    logic        stall;
    logic [4:0]  rf_sel;
    logic [15:0] rf_rdata;
    logic [15:0] rf_wdata;
    logic        rf_load_L;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [2:0]  depth;
    logic        underflow;

    // Controller side
    modport master (
        input  win_req, index, rf_rdata, mem_rdata, mem_ack,
        output win_go, stall, rf_sel, rf_wdata, rf_load_L,
               mem_req, mem_we, mem_addr, mem_wdata, depth, underflow
    );

    // Environment side: control unit, register file and memory
    modport slave (
        output win_req, index, rf_rdata, mem_rdata, mem_ack,
        input  win_go, stall, rf_sel, rf_wdata, rf_load_L,
               mem_req, mem_we, mem_addr, mem_wdata, depth, underflow
    );

endinterface

// File: rtl/window_spill_fill_register.sv
// Generic loadable register with asynchronous active-low reset to a parameterised value.
module register #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d when load is asserted
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/window_spill_fill.sv
// Register-window controller: passes saves/restores through to the register file and
// spills the oldest window to / fills it back from a memory stack when the file is full/empty.
module window_spill_fill #(
    parameter int          NUM_WIN    = window_pkg::NUM_WIN,
    parameter logic [15:0] SPILL_BASE = window_pkg::SPILL_BASE
) (
    input  logic                clock,
    input  logic                reset_L,
    window_spill_fill_if.master bus
);
    import window_pkg::*;

    localparam logic [2:0] DEPTH_MAX = 3'(NUM_WIN - 1);
    localparam logic [1:0] K_LAST    = 2'(WIN_REGS - 1);

    state_t      state_reg, state_next;
    logic [2:0]  depth_reg, depth_next;
    logic [1:0]  k_reg, k_next;
    logic [4:0]  base_reg, base_next;      // physical register of word 0 of the window being moved
    logic [1:0]  dir_reg, dir_next;        // win_go value to emit in GO
    logic        underflow_reg, underflow_next;
    logic [15:0] sp;
    logic [15:0] sp_d;
    logic        sp_load;
    logic        save_req, restore_req;

    assign save_req    = (bus.win_req == WIN_SAVE);
    assign restore_req = (bus.win_req == WIN_RESTORE);

    register #(
        .WIDTH       (16),
        .RESET_VALUE (SPILL_BASE)
    ) u_sp (
        .clock   (clock),
        .reset_L (reset_L),
        .load    (sp_load),
        .d       (sp_d),
        .q       (sp)
    );

    // FSM state and bookkeeping registers
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_reg     <= IDLE;
            depth_reg     <= 3'd1;
            k_reg         <= 2'd0;
            base_reg      <= 5'd0;
            dir_reg       <= WIN_NONE;
            underflow_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            depth_reg     <= depth_next;
            k_reg         <= k_next;
            base_reg      <= base_next;
            dir_reg       <= dir_next;
            underflow_reg <= underflow_next;
        end
    end

    // Next-state logic: requests are only looked at in IDLE
    always_comb begin
        state_next     = state_reg;
        depth_next     = depth_reg;
        k_next         = k_reg;
        base_next      = base_reg;
        dir_next       = dir_reg;
        underflow_next = underflow_reg;
        sp_load        = 1'b0;
        sp_d           = sp;
        case (state_reg)
            IDLE: begin
                k_next = 2'd0;
                if (save_req) begin
                    dir_next = WIN_SAVE;
                    if (depth_reg < DEPTH_MAX) begin
                        state_next = GO;
                        depth_next = depth_reg + 3'd1;
                    end else begin
                        // Oldest resident window starts 4*(depth-1) below the current one
                        state_next = SPILL;
                        base_next  = bus.index - {depth_reg - 3'd1, 2'b00};
                    end
                end else if (restore_req) begin
                    dir_next = WIN_RESTORE;
                    if (depth_reg > 3'd1) begin
                        state_next = GO;
                        depth_next = depth_reg - 3'd1;
                    end else if (sp != SPILL_BASE) begin
                        state_next = FILL;
                        base_next  = bus.index - 5'(WIN_REGS);
                    end else begin
                        underflow_next = 1'b1;
                    end
                end
            end
            SPILL, FILL: begin
                if (bus.mem_ack) begin
                    k_next = k_reg + 2'd1;
                    if (k_reg == K_LAST) begin
                        // Spill frees one slot that the pending save reuses, so depth is unchanged
                        state_next = GO;
                        sp_load    = 1'b1;
                        sp_d       = (state_reg == SPILL) ? sp + 16'(WIN_REGS)
                                                          : sp - 16'(WIN_REGS);
                    end
                end
            end
            GO:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state; memory signals only change when k advances on an ack
    always_comb begin
        bus.win_go    = WIN_NONE;
        bus.stall     = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 16'd0;
        bus.mem_wdata = 16'd0;
        bus.rf_sel    = 5'd0;
        bus.rf_wdata  = 16'd0;
        bus.rf_load_L = 1'b1;
        case (state_reg)
            SPILL: begin
                bus.stall     = 1'b1;
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = sp + 16'(k_reg);
                bus.rf_sel    = base_reg + 5'(k_reg);
                bus.mem_wdata = bus.rf_rdata;
            end
            FILL: begin
                bus.stall     = 1'b1;
                bus.mem_req   = 1'b1;
                bus.mem_addr  = sp - 16'(WIN_REGS) + 16'(k_reg);
                bus.rf_sel    = base_reg + 5'(k_reg);
                bus.rf_wdata  = bus.mem_rdata;
                bus.rf_load_L = ~bus.mem_ack;
            end
            GO:      bus.win_go = dir_reg;
            default: ;
        endcase
    end

    assign bus.depth     = depth_reg;
    assign bus.underflow = underflow_reg;

endmodule

// File: tb/tb_window_spill_fill.sv
// Self-checking bench: directed vector table, randomized ops against a window-stack model,
// and a reset-in-the-middle-of-a-spill sequence.
module tb_window_spill_fill;
    import window_pkg::*;

    localparam logic [1:0]  SV   = 2'b10;
    localparam logic [1:0]  RS   = 2'b01;
    localparam logic [15:0] BASE = 16'hF000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    window_spill_fill_if bus();

    window_spill_fill #(
        .NUM_WIN    (8),
        .SPILL_BASE (BASE)
    ) dut (
        .clock   (clk),
        .reset_L (rst_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Register file and memory models
    logic [15:0] rf_arr  [32];
    logic [15:0] mem_arr [65536];
    int          ack_delay = 0;
    int          wait_cnt;

    assign bus.rf_rdata  = rf_arr[bus.rf_sel];
    assign bus.mem_rdata = mem_arr[bus.mem_addr];
    assign bus.mem_ack   = bus.mem_req && (wait_cnt >= ack_delay);

    // Register file write port
    always @(posedge clk) begin
        if (!bus.rf_load_L) rf_arr[bus.rf_sel] <= bus.rf_wdata;
    end

    // Memory with programmable ack latency
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 0;
        end else if (bus.mem_req) begin
            if (bus.mem_ack) begin
                wait_cnt <= 0;
                if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    // A request still waiting for its ack must keep address, data and direction
    logic        pend = 1'b0;
    logic [15:0] p_addr, p_wdata;
    logic        p_we;
    always @(negedge clk) begin
        if (pend && bus.mem_req) begin
            n_cmp++;
            if ({bus.mem_addr, bus.mem_wdata, bus.mem_we} !== {p_addr, p_wdata, p_we}) begin
                n_bad++;
                $display("FAIL mem_hold: got addr=%h wdata=%h we=%b want addr=%h wdata=%h we=%b",
                         bus.mem_addr, bus.mem_wdata, bus.mem_we, p_addr, p_wdata, p_we);
            end
        end
        pend    = bus.mem_req && !bus.mem_ack;
        p_addr  = bus.mem_addr;
        p_wdata = bus.mem_wdata;
        p_we    = bus.mem_we;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: resident-window count plus a LIFO of spilled windows
    int          m_depth;
    logic [63:0] stack [$];
    logic        m_uf;
    logic [1:0]  m_go;
    int          m_stall;
    logic [4:0]  cwp = 5'd0;

    // Observations of the last op
    logic [1:0]  o_go;
    int          o_stall;
    logic        o_memreq;

    task automatic model_reset();
        m_depth = 1;
        stack.delete();
        m_uf = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_win_go"},    bus.win_go, 2'b00);
        chk({tag, "_stall"},     bus.stall, 1'b0);
        chk({tag, "_mem_req"},   {bus.mem_req, bus.mem_we}, 2'b00);
        chk({tag, "_rf_load_L"}, bus.rf_load_L, 1'b1);
        chk({tag, "_mem_bus"},   {bus.mem_addr, bus.mem_wdata}, 32'd0);
        chk({tag, "_rf_bus"},    {bus.rf_sel, bus.rf_wdata}, 21'd0);
        chk({tag, "_depth"},     bus.depth, 3'd1);
        chk({tag, "_underflow"}, bus.underflow, 1'b0);
        chk({tag, "_sp"},        dut.sp, BASE);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.win_req = 2'b00;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    // Hold win_req until win_go shows up (or the op is evidently a no-op), bounded
    task automatic do_op(input logic [1:0] req, input int delay);
        ack_delay   = delay;
        bus.win_req = req;
        o_go        = 2'b00;
        o_stall     = 0;
        o_memreq    = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (bus.stall) o_stall++;
            if (bus.mem_req) o_memreq = 1'b1;
            if (bus.win_go != 2'b00) begin
                o_go = bus.win_go;
                break;
            end
            if (c >= 4 && !bus.stall) break;
        end
        bus.win_req = 2'b00;
    endtask

    task automatic run_op(input logic [1:0] req, input int delay);
        logic [63:0] w;
        int          kind;
        for (int i = 0; i < 32; i++) rf_arr[i] = 16'($urandom);
        bus.index = cwp;
        m_go    = 2'b00;
        m_stall = 0;
        kind    = 0;
        w       = '0;
        if (req == SV) begin
            m_go = SV;
            if (m_depth < 7) begin
                m_depth++;
            end else begin
                for (int k = 0; k < 4; k++)
                    w[16*k +: 16] = rf_arr[5'((int'(cwp) - 4 * (m_depth - 1) + k) & 31)];
                stack.push_back(w);
                m_stall = 4 * (delay + 1);
                kind    = 1;
            end
        end else if (req == RS) begin
            if (m_depth > 1) begin
                m_depth--;
                m_go = RS;
            end else if (stack.size() > 0) begin
                w       = stack.pop_back();
                m_go    = RS;
                m_stall = 4 * (delay + 1);
                kind    = 2;
            end else begin
                m_uf = 1'b1;
            end
        end
        do_op(req, delay);
        chk("op_done", bus.stall, 1'b0);
        if (kind == 1)
            for (int k = 0; k < 4; k++)
                chk("spill_data", mem_arr[16'(32'(BASE) + 4 * (stack.size() - 1) + k)], w[16*k +: 16]);
        if (kind == 2)
            for (int k = 0; k < 4; k++)
                chk("fill_data", rf_arr[5'((int'(cwp) - 4 + k) & 31)], w[16*k +: 16]);
        if (o_go == SV)      cwp = cwp + 5'd4;
        else if (o_go == RS) cwp = cwp - 5'd4;
        if (o_go != 2'b00) begin
            @(negedge clk);
            chk("go_pulse", bus.win_go, 2'b00);
        end
        $display("op req=%b delay=%0d go=%b stall=%0d depth=%0d sp=%h uf=%b",
                 req, delay, o_go, o_stall, bus.depth, dut.sp, bus.underflow);
    endtask

    typedef struct {
        logic [1:0]  req;
        int          delay;
        logic [1:0]  go;
        int          stall;
        int          depth;
        logic [15:0] sp;
        logic        uf;
    } vec_t;
    vec_t vq [$];

    function automatic void add(logic [1:0] req, int delay, logic [1:0] go, int stall,
                                int depth, logic [15:0] sp, logic uf);
        vec_t v;
        v.req = req; v.delay = delay; v.go = go; v.stall = stall;
        v.depth = depth; v.sp = sp; v.uf = uf;
        vq.push_back(v);
    endfunction

    initial begin
        int acks;
        logic [1:0] req;
        int rr;

        for (int i = 0; i < 65536; i++) mem_arr[i] = 16'd0;
        for (int i = 0; i < 32; i++) rf_arr[i] = 16'd0;
        bus.win_req = 2'b00;
        bus.index   = 5'd0;

        // Directed table: saves to full, spill, restores to 1, fill, underflow, ignored codes,
        // then a spill with 3 wait states and a fill with 1 wait state
        for (int d = 2; d <= 7; d++) add(SV, 0, SV, 0, d, BASE, 1'b0);
        add(SV, 0, SV, 4, 7, 16'hF004, 1'b0);
        for (int d = 6; d >= 1; d--) add(RS, 0, RS, 0, d, 16'hF004, 1'b0);
        add(RS, 0, RS, 4, 1, BASE, 1'b0);
        add(RS, 0, 2'b00, 0, 1, BASE, 1'b1);
        add(2'b11, 0, 2'b00, 0, 1, BASE, 1'b1);
        add(2'b00, 0, 2'b00, 0, 1, BASE, 1'b1);
        for (int d = 2; d <= 7; d++) add(SV, 0, SV, 0, d, BASE, 1'b1);
        add(SV, 3, SV, 16, 7, 16'hF004, 1'b1);
        for (int d = 6; d >= 1; d--) add(RS, 2, RS, 0, d, 16'hF004, 1'b1);
        add(RS, 1, RS, 8, 1, BASE, 1'b1);

        cwp = 5'd0;
        do_reset();
        foreach (vq[i]) begin
            run_op(vq[i].req, vq[i].delay);
            chk("go",           o_go, vq[i].go);
            chk("stall_cycles", o_stall, vq[i].stall);
            chk("mem_req_seen", o_memreq, vq[i].stall != 0);
            chk("depth",        bus.depth, vq[i].depth);
            chk("sp",           dut.sp, vq[i].sp);
            chk("underflow",    bus.underflow, vq[i].uf);
        end

        // Randomized ops: save-biased first half, restore-biased second half
        do_reset();
        for (int i = 0; i < 80; i++) begin
            rr = $urandom_range(0, 9);
            if (rr == 0)      req = 2'b00;
            else if (rr == 1) req = 2'b11;
            else if (i < 40)  req = (rr < 7) ? SV : RS;
            else              req = (rr < 7) ? RS : SV;
            run_op(req, $urandom_range(0, 3));
            chk("rnd_go",        o_go, m_go);
            chk("rnd_stall",     o_stall, m_stall);
            chk("rnd_mem_req",   o_memreq, m_stall != 0);
            chk("rnd_depth",     bus.depth, m_depth);
            chk("rnd_sp",        dut.sp, 16'(32'(BASE) + 4 * stack.size()));
            chk("rnd_underflow", bus.underflow, m_uf);
        end

        // Reset arriving after the second ack of a spill aborts it with no sp/depth update
        do_reset();
        for (int i = 0; i < 6; i++) run_op(SV, 0);
        chk("pre_abort_depth", bus.depth, 3'd7);
        bus.index   = cwp;
        ack_delay   = 1;
        bus.win_req = SV;
        acks        = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.mem_req && bus.mem_ack) acks++;
            if (acks == 2) break;
        end
        chk("abort_two_acks", acks, 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        bus.win_req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
        chk("abort_idle_stall", bus.stall, 1'b0);
        $display("op abort-reset depth=%0d sp=%h", bus.depth, dut.sp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
